// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite round-robin arbiter: response codes,
// per-path FSM state encodings and the round-robin pointer step.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  // Next round-robin pointer after serving idx. The wrap is explicit so
  // non-power-of-two master counts never land on an unused index.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axi_lite_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr, wrapping past NUM_M-1 back to 0.
module axi_lite_rr_pick #(
  parameter  int NUM_M = 2,
  localparam int IDX_W = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_req
);

  // Scan NUM_M slots starting at ptr; the first hit wins.
  always_comb begin
    int j;
    j       = 0;
    gnt_idx = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_M) begin
        j = j - NUM_M;
      end
      if (!any_req && req[j]) begin
        any_req = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// AXI4-Lite N:1 arbiter. Write (AW/W/B) and read (AR/R) paths each run their
// own round-robin grant and carry one outstanding transaction; the grant is
// held from address acceptance until the response handshake.
module axi_lite_rr_arbiter
  import axi_lite_pkg::*;
#(
  parameter  int NUM_M  = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int IDX_W  = $clog2(NUM_M)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // upstream masters
  input  logic [NUM_M*ADDR_W-1:0]   s_awaddr,
  input  logic [NUM_M-1:0]          s_awvalid,
  output logic [NUM_M-1:0]          s_awready,
  input  logic [NUM_M*DATA_W-1:0]   s_wdata,
  input  logic [NUM_M*STRB_W-1:0]   s_wstrb,
  input  logic [NUM_M-1:0]          s_wvalid,
  output logic [NUM_M-1:0]          s_wready,
  output logic [1:0]                s_bresp,
  output logic [NUM_M-1:0]          s_bvalid,
  input  logic [NUM_M-1:0]          s_bready,
  input  logic [NUM_M*ADDR_W-1:0]   s_araddr,
  input  logic [NUM_M-1:0]          s_arvalid,
  output logic [NUM_M-1:0]          s_arready,
  output logic [DATA_W-1:0]         s_rdata,
  output logic [1:0]                s_rresp,
  output logic [NUM_M-1:0]          s_rvalid,
  input  logic [NUM_M-1:0]          s_rready,
  // downstream slave
  output logic [ADDR_W-1:0]         m_awaddr,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_W-1:0]         m_wdata,
  output logic [STRB_W-1:0]         m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  // debug
  output logic [IDX_W-1:0]          wr_grant,
  output logic [IDX_W-1:0]          rd_grant
);

  // Per-master views of the packed upstream buses.
  logic [ADDR_W-1:0] awaddr_arr [NUM_M];
  logic [ADDR_W-1:0] araddr_arr [NUM_M];
  logic [DATA_W-1:0] wdata_arr  [NUM_M];
  logic [STRB_W-1:0] wstrb_arr  [NUM_M];

  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
    assign awaddr_arr[gi] = s_awaddr[gi*ADDR_W +: ADDR_W];
    assign araddr_arr[gi] = s_araddr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi]  = s_wdata[gi*DATA_W +: DATA_W];
    assign wstrb_arr[gi]  = s_wstrb[gi*STRB_W +: STRB_W];
  end

  // ---------------------------------------------------------------- write
  wr_state_e        wr_state_q, wr_state_d;
  logic [IDX_W-1:0] wr_grant_q, wr_grant_d;
  logic [IDX_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic             aw_done_q,  aw_done_d;
  logic             w_done_q,   w_done_d;
  logic [IDX_W-1:0] wr_pick_idx;
  logic             wr_any_req;

  axi_lite_rr_pick #(.NUM_M(NUM_M)) u_wr_pick (
    .req     (s_awvalid),
    .ptr     (wr_ptr_q),
    .gnt_idx (wr_pick_idx),
    .any_req (wr_any_req)
  );

  // Write state register; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      wr_grant_q <= '0;
      wr_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_grant_q <= wr_grant_d;
      wr_ptr_q   <= wr_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Write next-state and channel routing for the granted master.
  always_comb begin
    logic aw_hs;
    logic w_hs;
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    wr_ptr_d   = wr_ptr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    s_awready  = '0;
    s_wready   = '0;
    s_bvalid   = '0;
    s_bresp    = 2'b00;
    m_awaddr   = '0;
    m_awvalid  = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;

    // Payload follows the owner for the whole grant so it stays stable.
    if (wr_state_q != W_IDLE) begin
      m_awaddr = awaddr_arr[wr_grant_q];
      m_wdata  = wdata_arr[wr_grant_q];
      m_wstrb  = wstrb_arr[wr_grant_q];
    end

    case (wr_state_q)
      W_IDLE: begin
        if (wr_any_req) begin
          wr_grant_d = wr_pick_idx;
          wr_state_d = W_XFER;
        end
      end
      W_XFER: begin
        m_awvalid             = s_awvalid[wr_grant_q] & ~aw_done_q;
        m_wvalid              = s_wvalid[wr_grant_q] & ~w_done_q;
        s_awready[wr_grant_q] = m_awready & ~aw_done_q;
        s_wready[wr_grant_q]  = m_wready & ~w_done_q;
        aw_hs                 = m_awvalid & m_awready;
        w_hs                  = m_wvalid & m_wready;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          wr_state_d = W_RESP;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      W_RESP: begin
        s_bvalid[wr_grant_q] = m_bvalid;
        s_bresp              = m_bresp;
        m_bready             = s_bready[wr_grant_q];
        if (m_bvalid && s_bready[wr_grant_q]) begin
          wr_ptr_d   = IDX_W'(rr_next(int'(wr_grant_q), NUM_M));
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- read
  rd_state_e        rd_state_q, rd_state_d;
  logic [IDX_W-1:0] rd_grant_q, rd_grant_d;
  logic [IDX_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [IDX_W-1:0] rd_pick_idx;
  logic             rd_any_req;

  axi_lite_rr_pick #(.NUM_M(NUM_M)) u_rd_pick (
    .req     (s_arvalid),
    .ptr     (rd_ptr_q),
    .gnt_idx (rd_pick_idx),
    .any_req (rd_any_req)
  );

  // Read state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      rd_grant_q <= '0;
      rd_ptr_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_grant_q <= rd_grant_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Read next-state and channel routing for the granted master.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant_d = rd_grant_q;
    rd_ptr_d   = rd_ptr_q;
    s_arready  = '0;
    s_rvalid   = '0;
    s_rdata    = '0;
    s_rresp    = 2'b00;
    m_araddr   = '0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;

    if (rd_state_q != R_IDLE) begin
      m_araddr = araddr_arr[rd_grant_q];
    end

    case (rd_state_q)
      R_IDLE: begin
        if (rd_any_req) begin
          rd_grant_d = rd_pick_idx;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid             = s_arvalid[rd_grant_q];
        s_arready[rd_grant_q] = m_arready;
        if (s_arvalid[rd_grant_q] && m_arready) begin
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        s_rvalid[rd_grant_q] = m_rvalid;
        s_rdata              = m_rdata;
        s_rresp              = m_rresp;
        m_rready             = s_rready[rd_grant_q];
        if (m_rvalid && s_rready[rd_grant_q]) begin
          rd_ptr_d   = IDX_W'(rr_next(int'(rd_grant_q), NUM_M));
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign wr_grant = wr_grant_q;
  assign rd_grant = rd_grant_q;

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Scoreboard bench for axi_lite_rr_arbiter: directed master traffic pushes
// expected downstream requests and upstream responses into queues; a slave
// model and a response monitor pop and compare as the DUT presents them.
module tb_axi_lite_rr_arbiter;
  import axi_lite_pkg::*;

  localparam int NM  = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int IW  = $clog2(NM);
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM*AW-1:0] s_awaddr = '0, s_araddr = '0;
  logic [NM*DW-1:0] s_wdata = '0;
  logic [NM*SW-1:0] s_wstrb = '0;
  logic [NM-1:0]    s_awvalid = '0, s_wvalid = '0, s_bready = '0, s_arvalid = '0, s_rready = '0;
  logic [NM-1:0]    s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]       s_bresp, s_rresp;
  logic [DW-1:0]    s_rdata;
  logic [AW-1:0]    m_awaddr, m_araddr;
  logic [DW-1:0]    m_wdata;
  logic [SW-1:0]    m_wstrb;
  logic             m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic             m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic             m_arready = 1'b0, m_rvalid = 1'b0;
  logic [1:0]       m_bresp = 2'b00, m_rresp = 2'b00;
  logic [DW-1:0]    m_rdata = '0;
  logic [IW-1:0]    wr_grant, rd_grant;

  axi_lite_rr_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  logic any_out;
  assign any_out = |{s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_bresp, s_rresp,
                     s_rdata, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
                     m_araddr, m_arvalid, m_rready, wr_grant, rd_grant};

  // ------------------------------------------------------------ scoreboard
  typedef struct { int m; logic [DW-1:0] data; logic [1:0] resp; } rsp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb; } dw_t;

  rsp_t          exp_b[$];
  rsp_t          exp_r[$];
  dw_t           exp_dw[$];
  logic [AW-1:0] exp_dr[$];

  int n_total = 0;
  int n_pass  = 0;
  int dw_cnt  = 0;
  int dr_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // --------------------------------------------------------- slave model
  int         aw_delay = 0;
  int         r_lat    = 0;
  logic [1:0] wr_resp_cfg = 2'b00, rd_resp_cfg = 2'b00;
  logic [DW-1:0] rd_data_cfg = '0;
  logic       aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;

  initial begin : slave
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, awv;
    logic [AW-1:0] aw_s, ar_s, aw_addr;
    logic [DW-1:0] w_s, wd;
    logic [SW-1:0] st_s, ws;
    int aw_cnt, r_cnt;
    dw_t e;
    aw_cnt = 0; r_cnt = 0; aw_addr = '0; wd = '0; ws = '0;
    forever begin
      @(posedge clk);
      aw_hs = m_awvalid && m_awready;
      w_hs  = m_wvalid && m_wready;
      b_hs  = m_bvalid && m_bready;
      ar_hs = m_arvalid && m_arready;
      r_hs  = m_rvalid && m_rready;
      awv   = m_awvalid;
      aw_s  = m_awaddr; ar_s = m_araddr; w_s = m_wdata; st_s = m_wstrb;
      #1;
      if (!rst_n) begin
        aw_got = 0; w_got = 0; ar_got = 0; aw_cnt = 0; r_cnt = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        continue;
      end
      if (aw_hs) begin aw_got = 1; aw_addr = aw_s; end
      else if (awv && !aw_got) aw_cnt++;
      if (w_hs) begin w_got = 1; wd = w_s; ws = st_s; end
      if (b_hs) begin
        m_bvalid = 0; m_bresp = 0; aw_got = 0; w_got = 0; aw_cnt = 0;
      end else if (aw_got && w_got && !m_bvalid) begin
        m_bvalid = 1; m_bresp = wr_resp_cfg; dw_cnt++;
        if (exp_dw.size() == 0) chk("dw_unexpected", 1, 0);
        else begin
          e = exp_dw.pop_front();
          chk("dw_addr", aw_addr, e.addr);
          chk("dw_data", wd, e.data);
          chk("dw_strb", ws, e.strb);
        end
      end
      m_awready = !aw_got && (aw_cnt >= aw_delay);
      m_wready  = !w_got;
      if (r_hs) begin m_rvalid = 0; m_rdata = 0; m_rresp = 0; ar_got = 0; end
      if (ar_hs) begin
        ar_got = 1; r_cnt = r_lat; dr_cnt++;
        if (exp_dr.size() == 0) chk("dr_unexpected", 1, 0);
        else chk("dr_addr", ar_s, exp_dr.pop_front());
      end else if (ar_got && !m_rvalid && !r_hs) begin
        if (r_cnt == 0) begin m_rvalid = 1; m_rdata = rd_data_cfg; m_rresp = rd_resp_cfg; end
        else r_cnt--;
      end
      m_arready = !ar_got;
    end
  end

  // -------------------------------------------------- response monitor
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (m_bready) chk("bready_after_aw_and_w", {aw_got, w_got}, 2'b11);
      for (int i = 0; i < NM; i++) begin
        if (s_bvalid[i] && s_bready[i]) begin
          if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
          else begin
            e = exp_b.pop_front();
            chk("b_master", i, e.m);
            chk("b_resp", s_bresp, e.resp);
            chk("b_wr_grant", wr_grant, e.m);
            chk("b_onehot", $onehot(s_bvalid), 1);
          end
        end
        if (s_rvalid[i] && s_rready[i]) begin
          if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
          else begin
            e = exp_r.pop_front();
            chk("r_master", i, e.m);
            chk("r_data", s_rdata, e.data);
            chk("r_resp", s_rresp, e.resp);
            chk("r_rd_grant", rd_grant, e.m);
            chk("r_onehot", $onehot(s_rvalid), 1);
          end
        end
      end
    end
  end

  // ------------------------------------------------------ master tasks
  task automatic m_write(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [SW-1:0] strb, input int aw_lead);
    fork
      begin
        int n; bit done;
        n = 0; done = 0;
        s_wdata[m*DW +: DW] = data; s_wstrb[m*SW +: SW] = strb; s_wvalid[m] = 1'b1;
        while (!done && n < TMO) begin
          @(posedge clk); n++;
          if (s_wvalid[m] && s_wready[m]) done = 1;
        end
        #1 s_wvalid[m] = 1'b0;
        chk("w_handshake_in_time", done, 1);
      end
      begin
        int n; bit done;
        n = 0; done = 0;
        if (aw_lead > 0) begin
          repeat (aw_lead) @(posedge clk);
          #1;
        end
        s_awaddr[m*AW +: AW] = addr; s_awvalid[m] = 1'b1;
        while (!done && n < TMO) begin
          @(posedge clk); n++;
          if (s_awvalid[m] && s_awready[m]) done = 1;
        end
        #1 s_awvalid[m] = 1'b0;
        chk("aw_handshake_in_time", done, 1);
      end
    join
    begin
      int n; bit done;
      n = 0; done = 0;
      s_bready[m] = 1'b1;
      while (!done && n < TMO) begin
        @(posedge clk); n++;
        if (s_bvalid[m] && s_bready[m]) done = 1;
      end
      #1 s_bready[m] = 1'b0;
      chk("b_handshake_in_time", done, 1);
    end
  endtask

  task automatic m_read(input int m, input logic [AW-1:0] addr);
    int n; bit done;
    n = 0; done = 0;
    s_araddr[m*AW +: AW] = addr; s_arvalid[m] = 1'b1;
    while (!done && n < TMO) begin
      @(posedge clk); n++;
      if (s_arvalid[m] && s_arready[m]) done = 1;
    end
    #1 s_arvalid[m] = 1'b0;
    chk("ar_handshake_in_time", done, 1);
    n = 0; done = 0;
    s_rready[m] = 1'b1;
    while (!done && n < TMO) begin
      @(posedge clk); n++;
      if (s_rvalid[m] && s_rready[m]) done = 1;
    end
    #1 s_rready[m] = 1'b0;
    chk("r_handshake_in_time", done, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs_zero", any_out, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic rsp_t rsp(input int m, input logic [DW-1:0] d, input logic [1:0] r);
    rsp_t x;
    x.m = m; x.data = d; x.resp = r;
    return x;
  endfunction

  function automatic dw_t dwr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    dw_t x;
    x.addr = a; x.data = d; x.strb = s;
    return x;
  endfunction

  // ------------------------------------------------------------ stimulus
  initial begin : stim
    do_reset();

    // single write from M0
    exp_dw.push_back(dwr(32'h10, 32'hDEADBEEF, 4'hF));
    exp_b.push_back(rsp(0, '0, OKAY));
    m_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 0);

    // contention straight after reset: M0, M1, then M0 again
    do_reset();
    exp_dw.push_back(dwr(32'h100, 32'hA0A0A0A0, 4'hF)); exp_b.push_back(rsp(0, '0, OKAY));
    exp_dw.push_back(dwr(32'h200, 32'hB1B1B1B1, 4'h1)); exp_b.push_back(rsp(1, '0, OKAY));
    fork
      m_write(0, 32'h100, 32'hA0A0A0A0, 4'hF, 0);
      m_write(1, 32'h200, 32'hB1B1B1B1, 4'h1, 0);
    join
    exp_dw.push_back(dwr(32'h104, 32'hA2A2A2A2, 4'hC)); exp_b.push_back(rsp(0, '0, OKAY));
    exp_dw.push_back(dwr(32'h204, 32'hB3B3B3B3, 4'h8)); exp_b.push_back(rsp(1, '0, OKAY));
    fork
      m_write(0, 32'h104, 32'hA2A2A2A2, 4'hC, 0);
      m_write(1, 32'h204, 32'hB3B3B3B3, 4'h8, 0);
    join

    // W three cycles before AW, slave AW ready delayed two cycles
    aw_delay = 2;
    exp_dw.push_back(dwr(32'h30, 32'hCAFEF00D, 4'h3));
    exp_b.push_back(rsp(1, '0, OKAY));
    m_write(1, 32'h30, 32'hCAFEF00D, 4'h3, 3);
    aw_delay = 0;

    // overlapping read (M0) and write (M1)
    r_lat = 3; rd_data_cfg = 32'h12345678; rd_resp_cfg = OKAY; wr_resp_cfg = OKAY;
    exp_dr.push_back(32'h20); exp_r.push_back(rsp(0, 32'h12345678, OKAY));
    exp_dw.push_back(dwr(32'h24, 32'h55AA55AA, 4'hF)); exp_b.push_back(rsp(1, '0, OKAY));
    fork
      m_read(0, 32'h20);
      m_write(1, 32'h24, 32'h55AA55AA, 4'hF, 0);
    join
    r_lat = 0;

    // SLVERR passthrough on M1 read, then rd_ptr back at 0 picks M0 first
    rd_data_cfg = 32'hBAD0BAD0; rd_resp_cfg = SLVERR;
    exp_dr.push_back(32'h40); exp_r.push_back(rsp(1, 32'hBAD0BAD0, SLVERR));
    m_read(1, 32'h40);
    rd_data_cfg = 32'h600DF00D; rd_resp_cfg = OKAY;
    exp_dr.push_back(32'h50); exp_r.push_back(rsp(0, 32'h600DF00D, OKAY));
    exp_dr.push_back(32'h60); exp_r.push_back(rsp(1, 32'h600DF00D, OKAY));
    fork
      m_read(0, 32'h50);
      m_read(1, 32'h60);
    join

    // decode error on a write is passed through untouched
    wr_resp_cfg = DECERR;
    exp_dw.push_back(dwr(32'h64, 32'h0000FFFF, 4'h5)); exp_b.push_back(rsp(0, '0, DECERR));
    m_write(0, 32'h64, 32'h0000FFFF, 4'h5, 0);
    wr_resp_cfg = OKAY;

    // reset while W_XFER has AW done but W outstanding
    begin
      int n; bit seen;
      n = 0; seen = 0;
      s_awaddr[0 +: AW] = 32'h80; s_awvalid[0] = 1'b1;
      while (!seen && n < TMO) begin
        @(posedge clk); n++;
        if (m_awvalid && m_awready) seen = 1;
      end
      chk("midop_aw_accepted", seen, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk("midop_reset_outputs_zero", any_out, 0);
      s_awvalid = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
    end
    exp_dw.push_back(dwr(32'h70, 32'h01020304, 4'hF)); exp_b.push_back(rsp(1, '0, OKAY));
    m_write(1, 32'h70, 32'h01020304, 4'hF, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("downstream_write_count", dw_cnt, 9);
    chk("downstream_read_count", dr_cnt, 4);
    chk("exp_b_drained", exp_b.size(), 0);
    chk("exp_r_drained", exp_r.size(), 0);
    chk("exp_dw_drained", exp_dw.size(), 0);
    chk("exp_dr_drained", exp_dr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
